// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-only slave that stores FIXED/INCR/WRAP bursts into a word-addressed scratch memory.
// Registered backdoor read port exposes memory contents to the consumer.
//   state  | meaning
//   S_IDLE | awready high, waiting for a write address
//   S_DATA | wready high, consuming len+1 beats
//   S_RESP | bvalid high, holding bid/bresp until bready
`timescale 1ns/1ps
module axi_wr_slave_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 64,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int ALSB       = $clog2(STRB_WIDTH),
  localparam int IDXW       = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int WAW = ADDR_WIDTH - ALSB;
  localparam logic [WAW-1:0] DEPTH_W = WAW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic [1:0]            bresp_q;
  logic                  cfg_err_q;
  logic                  rng_err_q;

  logic                  aw_hs, w_hs, last_beat, in_range, aw_cfg_err, wrap_len_ok;
  logic [WAW-1:0]        word_addr;
  logic [IDXW-1:0]       mem_idx;
  logic [ADDR_WIDTH-1:0] incr_addr, wrap_total, wrap_base, wrap_next, next_addr;

  // Beat count comes from awlen alone; wlast is accepted but never trusted.
  logic unused_wlast;
  assign unused_wlast = wlast;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign last_beat = (cnt_q == len_q);
  assign word_addr = addr_q[ADDR_WIDTH-1:ALSB];
  assign in_range  = (word_addr < DEPTH_W);
  assign mem_idx   = word_addr[IDXW-1:0];

  assign wrap_len_ok = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
  assign aw_cfg_err  = (awsize != 3'(ALSB)) || (awburst == 2'b11) ||
                       ((awburst == 2'b10) && (!wrap_len_ok || (awaddr[ALSB-1:0] != '0)));

  always_comb begin
    incr_addr  = {addr_q[ADDR_WIDTH-1:ALSB], {ALSB{1'b0}}} + ADDR_WIDTH'(STRB_WIDTH);
    wrap_total = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << ALSB;
    wrap_base  = addr_q & ~(wrap_total - ADDR_WIDTH'(1));
    wrap_next  = addr_q + ADDR_WIDTH'(STRB_WIDTH);
    if (wrap_next == wrap_base + wrap_total) wrap_next = wrap_base;
    case (burst_q)
      2'b01:   next_addr = incr_addr;
      2'b10:   next_addr = wrap_next;
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (!areset) begin
      case (state_q)
        S_IDLE: begin
          awready = 1'b1;
          if (awvalid) state_d = S_DATA;
        end
        S_DATA: begin
          wready = 1'b1;
          if (wvalid && last_beat) state_d = S_RESP;
        end
        S_RESP: begin
          bvalid = 1'b1;
          if (bready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      bresp_q   <= 2'b00;
      cfg_err_q <= 1'b0;
      rng_err_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q      <= awid;
        addr_q    <= awaddr;
        len_q     <= awlen;
        burst_q   <= awburst;
        cnt_q     <= '0;
        cfg_err_q <= aw_cfg_err;
        rng_err_q <= 1'b0;
      end
      if (w_hs) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 8'd1;
        if (!in_range) rng_err_q <= 1'b1;
        if (last_beat)
          bresp_q <= (cfg_err_q || rng_err_q || !in_range) ? 2'b10 : 2'b00;
      end
    end
  end

  // Out-of-range beats are dropped individually; a bad AW config drops the whole burst.
  always_ff @(posedge aclk) begin
    if (w_hs && in_range && !cfg_err_q) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_data <= '0;
    else        rd_data <= mem[rd_idx];
  end

  assign bid   = id_q;
  assign bresp = bresp_q;

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: directed and random bursts against an address-list memory model,
// B responses checked by a queue-driven monitor, memory checked through the backdoor port.
`timescale 1ns/1ps
module tb_axi_wr_slave_mem;

  localparam int DW = 128;
  localparam int SW = 16;
  localparam int DEPTH = 64;

  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    awid;
  logic [15:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [5:0]    rd_idx;
  logic [DW-1:0] rd_data;

  axi_wr_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  bexp_t         bq[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] bd [256];
  logic [SW-1:0] bs [256];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never seen within cycle budget", name);
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Byte address of beat i, straight from the burst rules.
  function automatic int beat_addr(input int a, input int len, input int burst, input int i);
    int total, base;
    case (burst)
      1: return (i == 0) ? a : (((a / SW) + i) * SW) % 65536;
      2: begin
        total = (len + 1) * SW;
        base  = a - (a % total);
        return base + ((a - base) + i * SW) % total;
      end
      default: return a;
    endcase
  endfunction

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_txn(input logic [3:0] id, input int addr, input int len, input int size,
                        input int burst, input int bdelay, input bit gaps);
    bit cfg_err, resp_err, wrap_ok;
    int a, idx, n;
    wrap_ok  = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    cfg_err  = (size != 4) || (burst == 3) || ((burst == 2) && (!wrap_ok || (addr % SW) != 0));
    resp_err = cfg_err;
    for (int i = 0; i <= len; i++) begin
      a   = beat_addr(addr, len, burst, i);
      idx = a / SW;
      if (idx >= DEPTH) resp_err = 1'b1;
      else if (!cfg_err)
        for (int b = 0; b < SW; b++)
          if (bs[i][b]) model_mem[idx][8*b +: 8] = bd[i][8*b +: 8];
    end
    bq.push_back('{id: id, resp: resp_err ? 2'b10 : 2'b00});

    awid = id; awaddr = 16'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin cyc(); n++; end
    if (!awready) timeout("aw_handshake");
    cyc();
    awvalid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; cyc(); end
      wdata  = bd[i];
      wstrb  = bs[i];
      wlast  = (i == len);
      if ($urandom_range(0, 7) == 0) wlast = ~wlast;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin cyc(); n++; end
      if (!wready) timeout("w_handshake");
      cyc();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    if (!bvalid) timeout("b_valid");
    repeat (bdelay) cyc();
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    check("bvalid_after_b", 128'(bvalid), 128'(0));
    check("awready_after_b", 128'(awready), 128'(1));
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 6'(i);
      cyc();
      check($sformatf("rd_data[%0d]", i), rd_data, model_mem[i]);
    end
  endtask

  // B-channel monitor: every bvalid cycle is compared against the oldest expected response.
  always @(negedge aclk) begin
    if (!areset && bvalid) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got bvalid=1 bid=%h bresp=%b expected no response", bid, bresp);
      end else begin
        check("bid", 128'(bid), 128'(bq[0].id));
        check("bresp", 128'(bresp), 128'(bq[0].resp));
        check("awready_in_resp", 128'(awready), 128'(0));
        if (bready) void'(bq.pop_front());
      end
    end
  end

  initial begin
    int r, burst, len, addr, size;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rd_idx = '0;
    repeat (3) cyc();
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_wready", 128'(wready), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_bresp", 128'(bresp), 128'(0));
    check("rst_bid", 128'(bid), 128'(0));
    check("rst_rd_data", rd_data, 128'(0));
    areset = 1'b0;
    #0;
    check("idle_awready", 128'(awready), 128'(1));

    for (int i = 0; i < 64; i++) begin bd[i] = rand128(); bs[i] = '1; end
    do_txn(4'h0, 0, 63, 4, 1, 0, 1'b0);
    readback();

    bd[0] = {16{8'h11}}; bd[1] = {16{8'h22}}; bd[2] = {16{8'h33}}; bd[3] = {16{8'h44}};
    for (int i = 0; i < 4; i++) bs[i] = '1;
    do_txn(4'h5, 'h000, 3, 4, 1, 5, 1'b0);

    bd[0] = {16{8'hA1}}; bd[1] = {16{8'hA2}}; bd[2] = {16{8'hA3}}; bd[3] = {16{8'hA4}};
    do_txn(4'h6, 'h020, 3, 4, 2, 1, 1'b0);

    bd[0] = rand128(); bd[1] = rand128(); bd[2] = rand128();
    bs[0] = 16'h000F; bs[1] = 16'hFFF0; bs[2] = 16'h0000;
    do_txn(4'h7, 'h040, 2, 4, 0, 0, 1'b0);

    bd[0] = rand128(); bd[1] = rand128(); bs[0] = '1; bs[1] = '1;
    do_txn(4'h8, 'h080, 1, 4, 3, 0, 1'b0);
    do_txn(4'h9, 'h080, 1, 3, 1, 2, 1'b0);
    do_txn(4'hA, 'h3F0, 1, 4, 1, 0, 1'b0);
    readback();

    // Reset in the middle of a data phase: first beat lands, no response follows.
    bd[0] = rand128();
    awid = 4'h2; awaddr = 16'h0100; awlen = 8'd3; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    wdata = bd[0]; wstrb = '1; wvalid = 1'b1;
    check("mid_wready", 128'(wready), 128'(1));
    cyc();
    model_mem[16] = bd[0];
    wvalid = 1'b0;
    areset = 1'b1;
    cyc();
    check("midrst_awready", 128'(awready), 128'(0));
    check("midrst_wready", 128'(wready), 128'(0));
    check("midrst_bvalid", 128'(bvalid), 128'(0));
    cyc();
    areset = 1'b0;
    #0;
    check("postrst_awready", 128'(awready), 128'(1));
    repeat (3) cyc();
    check("postrst_bvalid", 128'(bvalid), 128'(0));

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      burst = (r < 4) ? 1 : (r < 7) ? 2 : (r < 9) ? 0 : 3;
      case (burst)
        2:       len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                                   : (2 << $urandom_range(0, 3)) - 1;
        0:       len = $urandom_range(0, 3);
        default: len = $urandom_range(0, 15);
      endcase
      addr = $urandom_range(0, 'h4FF);
      if ($urandom_range(0, 4) != 0) addr = addr & ~(SW - 1);
      size = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 4;
      for (int i = 0; i <= len; i++) begin
        bd[i] = rand128();
        bs[i] = 16'($urandom);
      end
      do_txn(4'($urandom), addr, len, size, burst, $urandom_range(0, 3), 1'b1);
      if (t % 10 == 9) readback();
    end

    repeat (2) cyc();
    check("b_queue_empty", 128'(bq.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
